bcd_counter_n: RTL

//  Parametrised N-digit BCD up/down counter with programmable terminal value,

---
 rtl/bcd_cnt_pkg.sv | 42 ++++
 rtl/bcd_digit.sv | 59 +++++
 rtl/bcd_counter_n.sv | 133 +++++++++++++
 3 files changed

// File: rtl/bcd_cnt_pkg.sv
// -----------------------------------------------------------------------------
// bcd_cnt_pkg
//  Shared types and helpers for the N-digit BCD counter:
//   BCD_W / BCD_MAX  width and largest legal value of one BCD digit
//   dir_e            count direction encoding
//   digit_ctl_t      per-digit control bundle formed by the top level
//   bcd_sat()        clamp a nibble into 0..9
//   bcd_gt()         magnitude compare of two BCD values (up to 8 digits)
// -----------------------------------------------------------------------------
package bcd_cnt_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'h9;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef struct packed {
    logic clr;
    logic load;
    logic inc;
    logic dec;
  } digit_ctl_t;

  function automatic logic [3:0] bcd_sat(input logic [3:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

  // Legal BCD digits order exactly like their binary nibbles, so the first
  // differing nibble from the top decides the comparison.
  function automatic logic bcd_gt(input logic [31:0] a, input logic [31:0] b);
    for (int i = 7; i >= 0; i--) begin
      if (a[i*4 +: 4] != b[i*4 +: 4]) begin
        return (a[i*4 +: 4] > b[i*4 +: 4]);
      end
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
//  One BCD digit register with wrap-around increment/decrement.
//  Ports:
//   CLK0      clock, rising edge
//   RST       asynchronous active-low reset (digit -> 0)
//   clr       synchronous clear (highest priority)
//   load      synchronous load of load_val
//   inc       step up, 9 -> 0
//   dec       step down, 0 -> 9
//   load_val  value taken on load (caller guarantees 0..9)
//   digit     current digit value
//   at_max    digit == 9
//   at_zero   digit == 0
// -----------------------------------------------------------------------------
module bcd_digit
  import bcd_cnt_pkg::*;
(
  input  logic             CLK0,
  input  logic             RST,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  input  logic [BCD_W-1:0] load_val,
  output logic [BCD_W-1:0] digit,
  output logic             at_max,
  output logic             at_zero
);

  logic [BCD_W-1:0] digit_reg;
  logic [BCD_W-1:0] digit_next;

  always_comb begin
    digit_next = digit_reg;
    if (clr) begin
      digit_next = '0;
    end else if (load) begin
      digit_next = load_val;
    end else if (inc) begin
      digit_next = (digit_reg == BCD_MAX) ? 4'h0 : digit_reg + 4'd1;
    end else if (dec) begin
      digit_next = (digit_reg == 4'h0) ? BCD_MAX : digit_reg - 4'd1;
    end
  end

  always_ff @(posedge CLK0 or negedge RST) begin
    if (!RST) begin
      digit_reg <= '0;
    end else begin
      digit_reg <= digit_next;
    end
  end

  assign digit   = digit_reg;
  assign at_max  = (digit_reg == BCD_MAX);
  assign at_zero = (digit_reg == 4'h0);

endmodule

// File: rtl/bcd_counter_n.sv
// -----------------------------------------------------------------------------
// bcd_counter_n
//  N-digit BCD up/down counter with programmable terminal value TOP.
//  Counting up, TOP wraps to 0; counting down, 0 wraps to TOP. Each digit's
//  step enable is a parallel AND of the lower digits' at_max/at_zero flags,
//  so no carry ripples through the digit registers.
//  Optional feature macro: BCD_CNT_LOAD_EN adds load/load_val with value
//  sanitising (nibbles clamped to 9, then the whole value clamped to TOP).
//  Parameters:
//   DIGITS    number of BCD digits (1..8)
//   TOP       BCD terminal count, every nibble 0..9
//  Ports:
//   CLK0      clock, rising edge
//   RST       asynchronous active-low reset (count=0, wrap=0)
//   en        count enable
//   up_dn     1 = up, 0 = down
//   clr       synchronous clear (beats load and en)
//   load      synchronous load (BCD_CNT_LOAD_EN only, beats en)
//   load_val  BCD value to load (BCD_CNT_LOAD_EN only)
//   count     current BCD count, digit 0 in bits [3:0]
//   tc        combinational terminal count: en and at the wrap point
//   wrap      registered one-cycle pulse in the cycle after a wrap edge
// -----------------------------------------------------------------------------
module bcd_counter_n
  import bcd_cnt_pkg::*;
#(
  parameter int                      DIGITS = 2,
  parameter logic [BCD_W*DIGITS-1:0] TOP    = {DIGITS{4'h9}}
)
(
  input  logic                      CLK0,
  input  logic                      RST,
  input  logic                      en,
  input  logic                      up_dn,
  input  logic                      clr,
`ifdef BCD_CNT_LOAD_EN
  input  logic                      load,
  input  logic [BCD_W*DIGITS-1:0]   load_val,
`endif
  output logic [BCD_W*DIGITS-1:0]   count,
  output logic                      tc,
  output logic                      wrap
);

  localparam int W = BCD_W * DIGITS;

  dir_e              dir;
  logic [W-1:0]      count_w;
  logic [W-1:0]      digit_src;     // per-digit value used whenever digits load
  logic [DIGITS-1:0] at_max_w;
  logic [DIGITS-1:0] at_zero_w;
  logic [DIGITS-1:0] low_max;       // all digits below this one are 9
  logic [DIGITS-1:0] low_zero;      // all digits below this one are 0
  logic              load_eff;
  logic              at_top;
  logic              all_zero;
  logic              step_up;
  logic              step_dn;
  logic              wrap_reg;
  digit_ctl_t        ctl [DIGITS];

  assign dir = up_dn ? DIR_UP : DIR_DOWN;

`ifdef BCD_CNT_LOAD_EN
  logic [W-1:0] load_sat;
  logic [W-1:0] load_san;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_sat
    assign load_sat[gi*BCD_W +: BCD_W] = bcd_sat(load_val[gi*BCD_W +: BCD_W]);
  end

  assign load_san  = bcd_gt(32'(load_sat), 32'(TOP)) ? TOP : load_sat;
  assign load_eff  = load;
  // An external load and a down-wrap never coincide (load blocks stepping),
  // so one mux feeds every digit's load_val.
  assign digit_src = load_eff ? load_san : TOP;
`else
  assign load_eff  = 1'b0;
  assign digit_src = TOP;
`endif

  assign at_top   = (count_w == TOP);
  assign all_zero = &at_zero_w;

  // Counting steps only happen when neither clr nor load claims the edge.
  assign step_up = en & (dir == DIR_UP)   & ~clr & ~load_eff;
  assign step_dn = en & (dir == DIR_DOWN) & ~clr & ~load_eff;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    if (gi == 0) begin : g_lsd
      assign low_max[gi]  = 1'b1;
      assign low_zero[gi] = 1'b1;
    end else begin : g_upper
      assign low_max[gi]  = &at_max_w[gi-1:0];
      assign low_zero[gi] = &at_zero_w[gi-1:0];
    end

    // Up-wrap at TOP clears every digit; down-wrap at 0 loads TOP into every
    // digit. Otherwise a digit steps when all lower digits are at their limit.
    assign ctl[gi] = '{
      clr:  clr | (step_up & at_top),
      load: ~clr & (load_eff | (step_dn & all_zero)),
      inc:  step_up & ~at_top & low_max[gi],
      dec:  step_dn & ~all_zero & low_zero[gi]
    };

    bcd_digit u_digit (
      .CLK0     (CLK0),
      .RST      (RST),
      .clr      (ctl[gi].clr),
      .load     (ctl[gi].load),
      .inc      (ctl[gi].inc),
      .dec      (ctl[gi].dec),
      .load_val (digit_src[gi*BCD_W +: BCD_W]),
      .digit    (count_w[gi*BCD_W +: BCD_W]),
      .at_max   (at_max_w[gi]),
      .at_zero  (at_zero_w[gi])
    );
  end

  always_ff @(posedge CLK0 or negedge RST) begin
    if (!RST) begin
      wrap_reg <= 1'b0;
    end else begin
      wrap_reg <= (step_up & at_top) | (step_dn & all_zero);
    end
  end

  assign count = count_w;
  assign tc    = en & ((up_dn & at_top) | (~up_dn & all_zero));
  assign wrap  = wrap_reg;

endmodule
